// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller and the PC block:
// FSM encoding, default vector layout and the id-width helper.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  localparam int unsigned IRQ_VEC_BASE   = 32'h100;
  localparam int unsigned IRQ_VEC_STRIDE = 32'd4;

  // A single source still needs a 1-bit id port.
  function automatic int irq_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: valid flag plus index of the first set bit.
module irq_prio_enc #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised multi-source interrupt controller with ack/EOI handshake.
// Define IRQ_NEST_EN to let a higher-priority source pre-empt one in service.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int                NUM_SRC    = 8,
  parameter int                ADDR_W     = 9,
  parameter int unsigned       VEC_BASE   = IRQ_VEC_BASE,
  parameter int unsigned       VEC_STRIDE = IRQ_VEC_STRIDE,
  parameter logic [NUM_SRC-1:0] EDGE_MODE = '1,
  localparam int               IW         = irq_id_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  output logic               isr,
  output logic [ADDR_W-1:0]  isr_vec,
  output logic [IW-1:0]      isr_id,
  input  logic               isr_ack,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] in_service
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] hist_q, epend_q, epend_d, mask_q, ins_q, ins_d;
  logic [NUM_SRC-1:0] cand, eclr;
  logic               isr_q, isr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [ADDR_W-1:0]  vec_q, vec_d;
  logic               cand_vld, ins_vld;
  logic [IW-1:0]      cand_idx, ins_idx;

  function automatic logic [ADDR_W-1:0] vec_of(input logic [IW-1:0] id);
    return ADDR_W'(VEC_BASE + VEC_STRIDE * 32'(id));
  endfunction

  // Level sources bypass the latch so that a dropped line withdraws at once.
  assign pending    = (epend_q & EDGE_MODE) | (irq_in & ~EDGE_MODE);
  assign cand       = pending & mask_q;
  assign in_service = ins_q;
  assign isr        = isr_q;
  assign isr_id     = id_q;
  assign isr_vec    = vec_q;

  irq_prio_enc #(.N(NUM_SRC), .IW(IW)) u_cand_enc (
    .req_i (cand),
    .vld_o (cand_vld),
    .idx_o (cand_idx)
  );

  irq_prio_enc #(.N(NUM_SRC), .IW(IW)) u_ins_enc (
    .req_i (ins_q),
    .vld_o (ins_vld),
    .idx_o (ins_idx)
  );

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    id_d    = id_q;
    vec_d   = vec_q;
    eclr    = '0;
    case (state_q)
      IRQ_IDLE: begin
        if (cand_vld) begin
          state_d = IRQ_REQ;
          id_d    = cand_idx;
          vec_d   = vec_of(cand_idx);
        end
      end
      IRQ_REQ: begin
        if (isr_ack) begin
          ins_d[id_q] = 1'b1;
          eclr[id_q]  = EDGE_MODE[id_q];
          state_d     = IRQ_SERVICE;
        end else if (!cand[id_q]) begin
          // Withdrawn: fall back to whatever is still being serviced.
          state_d = (ins_q != '0) ? IRQ_SERVICE : IRQ_IDLE;
        end
      end
      IRQ_SERVICE: begin
        if (eoi && ins_vld) begin
          ins_d[ins_idx] = 1'b0;
          if (ins_d == '0) state_d = IRQ_IDLE;
        end
`ifdef IRQ_NEST_EN
        else if (cand_vld && (cand_idx < ins_idx)) begin
          state_d = IRQ_REQ;
          id_d    = cand_idx;
          vec_d   = vec_of(cand_idx);
        end
`endif
      end
      default: state_d = IRQ_IDLE;
    endcase
    // A fresh edge beats an ack-clear landing in the same cycle.
    epend_d = (epend_q & ~eclr) | (irq_in & ~hist_q & EDGE_MODE);
    isr_d   = (state_d == IRQ_REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IRQ_IDLE;
      hist_q  <= '0;
      epend_q <= '0;
      mask_q  <= '0;
      ins_q   <= '0;
      isr_q   <= 1'b0;
      id_q    <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= irq_in;
      epend_q <= epend_d;
      if (mask_we) mask_q <= mask_wdata;
      ins_q   <= ins_d;
      isr_q   <= isr_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic against a
// queue-based behavioural model; source 0 is level sensitive, the rest edge.
module tb_irq_ctrl;
  localparam int N  = 8;
  localparam int AW = 9;
  localparam logic [N-1:0] EDGE = 8'hFE;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          mask_we = 1'b0;
  logic [N-1:0]  mask_wdata = '0;
  logic          isr_ack = 1'b0;
  logic          eoi = 1'b0;
  logic          isr;
  logic [AW-1:0] isr_vec;
  logic [2:0]    isr_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  in_service;

  irq_ctrl #(.NUM_SRC(N), .ADDR_W(AW), .EDGE_MODE(EDGE)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .isr        (isr),
    .isr_vec    (isr_vec),
    .isr_id     (isr_id),
    .isr_ack    (isr_ack),
    .eoi        (eoi),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: latched edge bits, mask, one outstanding request, list of ids in service.
  logic [N-1:0] m_pend, m_hist, m_mask;
  bit           m_req;
  int           m_id;
  int           svc[$];

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] svc_bits();
    logic [N-1:0] b = '0;
    foreach (svc[k]) b[svc[k]] = 1'b1;
    return b;
  endfunction

  function automatic int svc_min();
    int m = N;
    foreach (svc[k]) if (svc[k] < m) m = svc[k];
    return m;
  endfunction

  function automatic logic [N-1:0] m_view();
    return (m_pend & EDGE) | (irq_in & ~EDGE);
  endfunction

  task automatic model_reset();
    m_pend = '0; m_hist = '0; m_mask = '0;
    m_req = 1'b0; m_id = 0;
    svc.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] cand, clr;
    int first, lo;
    cand  = m_view() & m_mask;
    clr   = '0;
    first = lowest(cand);
    if (!m_req && svc.size() == 0) begin
      if (first >= 0) begin m_req = 1'b1; m_id = first; end
    end else if (m_req) begin
      if (isr_ack) begin
        svc.push_back(m_id);
        if (EDGE[m_id]) clr[m_id] = 1'b1;
        m_req = 1'b0;
      end else if (!cand[m_id]) begin
        m_req = 1'b0;
      end
    end else if (eoi) begin
      lo = svc_min();
      for (int k = 0; k < svc.size(); k++) begin
        if (svc[k] == lo) begin svc.delete(k); break; end
      end
    end else if (NEST && first >= 0 && first < svc_min()) begin
      m_req = 1'b1; m_id = first;
    end
    m_pend = (m_pend & ~clr) | (irq_in & ~m_hist & EDGE);
    m_hist = irq_in;
    if (mask_we) m_mask = mask_wdata;
  endtask

  task automatic check_model();
    chk("isr", 32'(isr), 32'(m_req));
    if (m_req) begin
      chk("isr_id", 32'(isr_id), 32'(m_id));
      chk("isr_vec", 32'(isr_vec), (32'h100 + 32'(4 * m_id)) & 32'h1FF);
    end
    chk("pending", 32'(pending), 32'(m_view()));
    chk("in_service", 32'(in_service), 32'(svc_bits()));
  endtask

  task automatic cyc(input logic [N-1:0] irq, input bit ack, input bit e,
                     input bit mwe, input logic [N-1:0] mwd);
    @(negedge clk);
    irq_in = irq; isr_ack = ack; eoi = e; mask_we = mwe; mask_wdata = mwd;
    @(posedge clk);
    model_step();
    #1 check_model();
  endtask

  task automatic idle(input logic [N-1:0] irq);
    cyc(irq, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_req || svc.size() != 0) && guard < 40) begin
      if (m_req) cyc('0, 1'b1, 1'b0, 1'b0, '0);
      else       cyc('0, 1'b0, 1'b1, 1'b0, '0);
      guard++;
    end
    chk("drain_timeout", 32'(guard >= 40), 32'd0);
  endtask

  task automatic run_random(input int cycles);
    logic [N-1:0] irq, mwd;
    bit ack, e, mwe;
    for (int c = 0; c < cycles; c++) begin
      irq = irq_in;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      ack = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      e   = (svc.size() != 0 && !m_req) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 15) == 0);
      mwe = ($urandom_range(0, 15) == 0);
      mwd = N'($urandom | $urandom);
      cyc(irq, ack, e, mwe, mwd);
    end
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_isr", 32'(isr), 32'd0);
    chk("rst_vec", 32'(isr_vec), 32'd0);
    chk("rst_id", 32'(isr_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Single edge source, 2-clock latency.
    cyc('0, 1'b0, 1'b0, 1'b1, 8'hFF);
    idle(8'h08);
    chk("lat_isr_early", 32'(isr), 32'd0);
    idle(8'h08);
    chk("t1_isr", 32'(isr), 32'd1);
    chk("t1_id", 32'(isr_id), 32'd3);
    chk("t1_vec", 32'(isr_vec), 32'h10C);
    cyc('0, 1'b1, 1'b0, 1'b0, '0);
    chk("t1_pend_clr", 32'(pending), 32'd0);
    chk("t1_ins", 32'(in_service), 32'h08);
    cyc('0, 1'b0, 1'b1, 1'b0, '0);
    chk("t1_eoi", 32'(in_service), 32'd0);
    idle('0);
    chk("t1_idle", 32'(isr), 32'd0);

    // Simultaneous edges: 2 first, then 5 without retrigger.
    idle(8'h24);
    idle('0);
    chk("t2_id_a", 32'(isr_id), 32'd2);
    chk("t2_vec_a", 32'(isr_vec), 32'h108);
    cyc('0, 1'b1, 1'b0, 1'b0, '0);
    cyc('0, 1'b0, 1'b1, 1'b0, '0);
    idle('0);
    chk("t2_isr_b", 32'(isr), 32'd1);
    chk("t2_id_b", 32'(isr_id), 32'd5);
    chk("t2_vec_b", 32'(isr_vec), 32'h114);
    drain();

    // Masked source stays pending, released by a mask write.
    cyc('0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle(8'h02);
    idle('0);
    chk("t3_masked_isr", 32'(isr), 32'd0);
    chk("t3_pending", 32'(pending), 32'h02);
    cyc('0, 1'b0, 1'b0, 1'b1, 8'h02);
    idle('0);
    chk("t3_isr", 32'(isr), 32'd1);
    chk("t3_id", 32'(isr_id), 32'd1);
    drain();
    cyc('0, 1'b0, 1'b0, 1'b1, 8'hFF);

    // Level source 0: ack does not clear, held line re-requests after eoi.
    idle(8'h01);
    chk("t4_isr", 32'(isr), 32'd1);
    chk("t4_vec", 32'(isr_vec), 32'h100);
    cyc(8'h01, 1'b1, 1'b0, 1'b0, '0);
    chk("t4_pend_held", 32'(pending), 32'h01);
    chk("t4_ins", 32'(in_service), 32'h01);
    idle('0);
    cyc('0, 1'b0, 1'b1, 1'b0, '0);
    idle('0);
    chk("t4_no_rereq", 32'(isr), 32'd0);
    idle(8'h01);
    cyc(8'h01, 1'b1, 1'b0, 1'b0, '0);
    cyc(8'h01, 1'b0, 1'b1, 1'b0, '0);
    idle(8'h01);
    chk("t4_rereq", 32'(isr), 32'd1);
    drain();

    // Higher-priority arrival while source 4 is in service.
    idle(8'h10);
    idle('0);
    chk("t5_id4", 32'(isr_id), 32'd4);
    cyc('0, 1'b1, 1'b0, 1'b0, '0);
    chk("t5_ins4", 32'(in_service), 32'h10);
    idle(8'h02);
    idle('0);
`ifdef IRQ_NEST_EN
    chk("t5_nest_isr", 32'(isr), 32'd1);
    chk("t5_nest_id", 32'(isr_id), 32'd1);
    cyc('0, 1'b1, 1'b0, 1'b0, '0);
    chk("t5_nest_ins", 32'(in_service), 32'h12);
    cyc('0, 1'b0, 1'b1, 1'b0, '0);
    chk("t5_nest_eoi", 32'(in_service), 32'h10);
`else
    chk("t5_no_nest_isr", 32'(isr), 32'd0);
    cyc('0, 1'b1, 1'b0, 1'b0, '0);
    chk("t5_ack_ignored", 32'(in_service), 32'h10);
    cyc('0, 1'b0, 1'b1, 1'b0, '0);
    chk("t5_eoi", 32'(in_service), 32'h00);
`endif
    drain();
    repeat (3) idle('0);
    drain();

    // Asynchronous reset while requesting.
    idle(8'h08);
    idle('0);
    chk("t6_req", 32'(isr), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("t6_isr", 32'(isr), 32'd0);
    chk("t6_pending", 32'(pending), 32'd0);
    chk("t6_ins", 32'(in_service), 32'd0);
    @(negedge clk); reset = 1'b1;
    idle(8'h08);
    idle('0);
    idle('0);
    chk("t6_mask_cleared", 32'(isr), 32'd0);
    chk("t6_pend_kept", 32'(pending), 32'h08);
    cyc('0, 1'b0, 1'b0, 1'b1, 8'hFF);
    idle('0);
    chk("t6_after_mask", 32'(isr), 32'd1);
    chk("t6_id", 32'(isr_id), 32'd3);
    drain();

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
